// File: rtl/stream_pkg.sv
// Shared stream definitions: default widths and the beat record used by the
// stream steering blocks (this demux and the matching stream_mux arbiter).
package stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 1;
    localparam int DEF_CNT_W = 8;

    // One stream beat: payload plus destination/source select.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_SEL_W-1:0] sel;
    } beat_t;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle of the stream demultiplexer: one select-tagged input
// stream and NOUT valid/ready output channels.
interface stream_demux_if
    import stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NOUT  = 2,
    parameter int SEL_W = DEF_SEL_W
) ();

    logic [WIDTH-1:0]      in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOUT*WIDTH-1:0] out_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;

    // Producer of input beats and consumer of the output channels.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // The demultiplexer itself.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry holding register for a single demux output channel.
// A load wins over a pop so a simultaneous pop+load streams with no bubble.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Slot state: reset clears, load fills, pop empties (data kept), else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (pop) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign dout  = data_r;

endmodule

// File: rtl/stream_demux.sv
// 1-to-NOUT valid/ready stream demultiplexer. Each beat is steered by its
// select field into a per-channel one-entry slot; out-of-range selects are
// consumed and counted in a saturating drop counter.
module stream_demux
    import stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NOUT  = 2,
    parameter int SEL_W = DEF_SEL_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    stream_demux_if.slave    bus,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] drop_count
);

    logic [NOUT-1:0]       hit_s;
    logic [NOUT-1:0]       valid_s;
    logic [NOUT-1:0]       load_s;
    logic [NOUT-1:0]       pop_s;
    logic [NOUT*WIDTH-1:0] data_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  drop_pulse_r;
    logic [CNT_W-1:0]      drop_count_r;

    // Decode the select into a one-hot channel hit; no hit means out of range.
    always_comb begin
        hit_s = {NOUT{1'b0}};
        for (int k = 0; k < NOUT; k++) begin
            hit_s[k] = (bus.in_sel == SEL_W'(k));
        end
    end

    // Only the addressed channel can stall the input; drops are always taken.
    assign ready_s  = !rst && !(|(hit_s & valid_s & ~bus.out_ready));
    assign accept_s = bus.in_valid & ready_s;
    assign load_s   = hit_s & {NOUT{accept_s}};
    assign pop_s    = valid_s & bus.out_ready;
    assign drop_s   = accept_s & ~(|hit_s);

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[k]),
            .pop   (pop_s[k]),
            .din   (bus.in_data),
            .valid (valid_s[k]),
            .dout  (data_s[k*WIDTH +: WIDTH])
        );
    end

    // Drop pulse and saturating drop counter for out-of-range beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse_r <= 1'b0;
            drop_count_r <= {CNT_W{1'b0}};
        end else begin
            drop_pulse_r <= drop_s;
            if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = data_s;
    assign drop_pulse    = drop_pulse_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_stream_demux.sv
// Table-driven bench for stream_demux: a 2-channel instance runs a vector
// table (reset, routing, backpressure, streaming, mid-run reset) and a
// 3-channel instance with a 2-bit counter runs the drop/saturation sequence.
module tb_stream_demux;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic       drop_pulse_a;
    logic [7:0] drop_count_a;
    logic       drop_pulse_b;
    logic [1:0] drop_count_b;

    int total;
    int bad;

    stream_demux_if #(.WIDTH(8), .NOUT(2), .SEL_W(1)) bus_a ();
    stream_demux_if #(.WIDTH(8), .NOUT(3), .SEL_W(2)) bus_b ();

    stream_demux #(.WIDTH(8), .NOUT(2), .SEL_W(1), .CNT_W(8)) dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .bus        (bus_a.slave),
        .drop_pulse (drop_pulse_a),
        .drop_count (drop_count_a)
    );

    stream_demux #(.WIDTH(8), .NOUT(3), .SEL_W(2), .CNT_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .bus        (bus_b.slave),
        .drop_pulse (drop_pulse_b),
        .drop_count (drop_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        vld;
        logic        sel;
        logic [7:0]  data;
        logic [1:0]  ordy;
        logic        exp_ir;
        logic [1:0]  exp_ov;
        logic [1:0]  chk;
        logic [15:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic s,
                                input logic [7:0] d, input logic [1:0] ordy,
                                input logic ir, input logic [1:0] ov,
                                input logic [1:0] chk, input logic [15:0] od);
        vec_t x;
        x.rst = r; x.vld = v; x.sel = s; x.data = d; x.ordy = ordy;
        x.exp_ir = ir; x.exp_ov = ov; x.chk = chk; x.exp_od = od;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_sel = 1'b0; bus_a.in_data = 8'h00; bus_a.out_ready = 2'b11;
        bus_b.in_valid = 1'b0; bus_b.in_sel = 2'd0; bus_b.in_data = 8'h00; bus_b.out_ready = 3'b111;

        // 1. reset with a beat offered
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'hAA, 2'b11, 1'b0, 2'b00, 2'b11, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'hAA, 2'b11, 1'b0, 2'b00, 2'b11, 16'h0000));
        // 2. routing and 1-cycle latency, single-cycle valids
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h11, 2'b11, 1'b1, 2'b01, 2'b01, 16'h0011));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h22, 2'b11, 1'b1, 2'b10, 2'b10, 16'h2200));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 2'b00, 2'b00, 16'h0000));
        // 3. backpressure on ch0, ch1 independent, then pop+load with no bubble
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 2'b10, 1'b1, 2'b01, 2'b01, 16'h0033));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h44, 2'b10, 1'b0, 2'b01, 2'b01, 16'h0033));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h55, 2'b10, 1'b1, 2'b11, 2'b11, 16'h5533));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h44, 2'b11, 1'b1, 2'b01, 2'b01, 16'h0044));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 2'b00, 2'b00, 16'h0000));
        // 4. 16 back-to-back beats to ch0
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'(i), 2'b11, 1'b1, 2'b01, 2'b01, {8'h00, 8'(i)}));
        end
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 2'b00, 2'b00, 16'h0000));
        // 6. both channels full and stalled, reset, then a lone beat on ch1
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h66, 2'b00, 1'b1, 2'b01, 2'b01, 16'h0066));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h77, 2'b00, 1'b1, 2'b11, 2'b11, 16'h7766));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h99, 2'b00, 1'b0, 2'b11, 2'b11, 16'h7766));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h99, 2'b00, 1'b0, 2'b00, 2'b11, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h88, 2'b00, 1'b1, 2'b10, 2'b10, 16'h8800));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_a           = vecs[i].rst;
            bus_a.in_valid  = vecs[i].vld;
            bus_a.in_sel    = vecs[i].sel;
            bus_a.in_data   = vecs[i].data;
            bus_a.out_ready = vecs[i].ordy;
            #1;
            check($sformatf("in_ready[%0d]", i), 32'(bus_a.in_ready), 32'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("out_valid[%0d]", i), 32'(bus_a.out_valid), 32'(vecs[i].exp_ov));
            for (int k = 0; k < 2; k++) begin
                if (vecs[i].chk[k]) begin
                    check($sformatf("out_data[%0d].ch%0d", i, k),
                          32'(bus_a.out_data[k*8 +: 8]), 32'(vecs[i].exp_od[k*8 +: 8]));
                end
            end
            check($sformatf("drop_pulse_a[%0d]", i), 32'(drop_pulse_a), 32'd0);
            check($sformatf("drop_count_a[%0d]", i), 32'(drop_count_a), 32'd0);
        end

        // 5. drop and saturation on the 3-channel instance with a 2-bit counter
        rst_b = 1'b1;
        bus_b.out_ready = 3'b111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b_reset_count", 32'(drop_count_b), 32'd0);
        check("b_reset_pulse", 32'(drop_pulse_b), 32'd0);
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_b.in_valid = 1'b1;
            bus_b.in_sel   = 2'd3;
            bus_b.in_data  = 8'(8'hC0 + i);
            #1;
            check($sformatf("b_drop_ready[%0d]", i), 32'(bus_b.in_ready), 32'd1);
            @(posedge clk); #1;
            check($sformatf("b_drop_pulse[%0d]", i), 32'(drop_pulse_b), 32'd1);
            check($sformatf("b_drop_count[%0d]", i), 32'(drop_count_b), (i < 3) ? 32'(i + 1) : 32'd3);
            check($sformatf("b_drop_valid[%0d]", i), 32'(bus_b.out_valid), 32'd0);
        end
        bus_b.in_valid = 1'b1;
        bus_b.in_sel   = 2'd2;
        bus_b.in_data  = 8'h5A;
        @(posedge clk); #1;
        check("b_idle_pulse", 32'(drop_pulse_b), 32'd0);
        check("b_held_count", 32'(drop_count_b), 32'd3);
        check("b_ch2_valid", 32'(bus_b.out_valid), 32'b100);
        check("b_ch2_data", 32'(bus_b.out_data[23:16]), 32'h5A);
        bus_b.in_valid = 1'b0;
        @(posedge clk); #1;
        check("b_ch2_popped", 32'(bus_b.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
